multdiv_ctrl: RTL

// Sequencing controller for the iterative multiply/divide unit in multdiv/. Accepts one-cycle

---
 rtl/multdiv_ctrl_pkg.sv | 17 +
 rtl/multdiv_iter_counter.sv | 31 +++
 rtl/multdiv_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/multdiv_ctrl_pkg.sv
// Shared definitions for the multiply/divide sequencing controller:
// the FSM state encoding and the default iteration count.
package multdiv_ctrl_pkg;

    // Datapath iterations per operation (one bit of the operand per step).
    localparam int MD_ITERS = 32;

    // Controller sequence: IDLE -> LOAD -> RUN -> FIN -> DONE -> IDLE.
    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_LOAD = 3'd1,
        MD_RUN  = 3'd2,
        MD_FIN  = 3'd3,
        MD_DONE = 3'd4
    } md_state_e;

endpackage

// File: rtl/multdiv_iter_counter.sv
// Down counter tracking the remaining datapath iterations.
// A synchronous load takes priority over the decrement; the count
// holds at zero instead of wrapping.
module multdiv_iter_counter #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld,
    input  logic [CW-1:0] ld_val,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          zero
);

    // Count register: reset, load, or saturating decrement.
    // NOTE: clocked state is written with non-blocking (<=) so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencing controller for the iterative multiply/divide unit.
// Turns a one-cycle start pulse into load / iterate / finalize strobes,
// short-cuts divide-by-zero straight to the result strobe, and reports
// the exception flag alongside a one-cycle result-ready strobe.
module multdiv_ctrl
    import multdiv_ctrl_pkg::*;
#(
    parameter int ITERS = MD_ITERS,
    parameter int CW    = $clog2(ITERS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ctrl_MULT,
    input  logic          ctrl_DIV,
    input  logic          divisor_zero,
    input  logic          mult_ovf,
    output logic          op_is_div,
    output logic          load_operands,
    output logic          iter_en,
    output logic [CW-1:0] iter_count,
    output logic          finalize,
    output logic          busy,
    output logic          data_resultRDY,
    output logic          data_exception
);

    md_state_e state_q;
    md_state_e state_d;
    logic      div_q;
    logic      exc_q;
    logic      start;
    logic      cnt_zero;

    // Either start pulse begins (or restarts) an operation from any state.
    assign start = ctrl_MULT | ctrl_DIV;

    multdiv_iter_counter #(
        .CW (CW)
    ) u_iter_counter (
        .clk    (clk),
        .reset  (reset),
        .ld     (state_q == MD_LOAD),
        .ld_val (CW'(ITERS - 1)),
        .en     (state_q == MD_RUN),
        .cnt    (iter_count),
        .zero   (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operation type: captured on every accepted start, divide wins a tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q <= 1'b0;
        end else if (start) begin
            div_q <= ctrl_DIV;
        end
    end

    // Exception flag: set by divide-by-zero in LOAD or overflow in FIN,
    // cleared whenever a new operation starts so aborted ops leave no trace.
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_q <= 1'b0;
        end else if (start) begin
            exc_q <= 1'b0;
        end else if (state_q == MD_LOAD) begin
            exc_q <= div_q & divisor_zero;
        end else if (state_q == MD_FIN) begin
            exc_q <= mult_ovf & ~div_q;
        end
    end

    // Next-state logic; a start pulse overrides every other transition.
    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = MD_LOAD;
        end else begin
            case (state_q)
                MD_IDLE: state_d = MD_IDLE;
                MD_LOAD: state_d = (div_q && divisor_zero) ? MD_DONE : MD_RUN;
                MD_RUN:  state_d = cnt_zero ? MD_FIN : MD_RUN;
                MD_FIN:  state_d = MD_DONE;
                MD_DONE: state_d = MD_IDLE;
                default: state_d = MD_IDLE;
            endcase
        end
    end

    // Moore output decode; the three datapath strobes come from distinct
    // states and so can never overlap.
    always_comb begin
        load_operands  = 1'b0;
        iter_en        = 1'b0;
        finalize       = 1'b0;
        busy           = 1'b0;
        data_resultRDY = 1'b0;
        data_exception = 1'b0;
        op_is_div      = div_q && (state_q != MD_IDLE);
        case (state_q)
            MD_LOAD: begin
                load_operands = 1'b1;
                busy          = 1'b1;
            end
            MD_RUN: begin
                iter_en = 1'b1;
                busy    = 1'b1;
            end
            MD_FIN: begin
                finalize = 1'b1;
                busy     = 1'b1;
            end
            MD_DONE: begin
                data_resultRDY = 1'b1;
                data_exception = exc_q;
            end
            default: ;
        endcase
    end

endmodule
